// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer
//   Time-multiplexed FIR filter. A single signed WIDTHxWIDTH multiplier and an
//   ACCW-bit accumulator are shared across NTAPS taps. Each accepted Q1.15
//   sample goes into a circular delay line. The block then runs NTAPS MAC
//   cycles and emits one rounded, saturated Q1.15 result.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous reset, active-high
//   x          input sample, Q1.15 signed
//   x_valid    x is presented
//   x_ready    block can accept x this cycle (IDLE and not in reset)
//   coef_we    coefficient write strobe, honoured only while idle
//   coef_addr  tap index k of h[k]
//   coef_data  coefficient value, Q1.15 signed
//   y          filtered output, held until the next result
//   y_valid    one-cycle pulse when y is updated
//   busy       a MAC sequence is in progress
module fir_tdm_sequencer #(
  parameter int NTAPS = 8,
  parameter int WIDTH = 16,
  parameter int ACCW  = 40
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           x,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [WIDTH-1:0]           coef_data,
  output logic [WIDTH-1:0]           y,
  output logic                       y_valid,
  output logic                       busy
);

  localparam int AW = $clog2(NTAPS);

  // Rounding bias (half an output LSB) and saturation limits at accumulator width.
  localparam logic signed [ACCW-1:0] HALF_LSB =
    {{(ACCW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]           k_reg, k_next;
  logic signed [ACCW-1:0]  acc_reg, acc_next;
  logic [WIDTH-1:0]        y_reg, y_next;
  logic                    y_valid_reg, y_valid_next;

  logic signed [WIDTH-1:0] coef_reg  [NTAPS];
  logic signed [WIDTH-1:0] delay_reg [NTAPS];

  logic                    accept;
  logic                    coef_wr_en;

  // Datapath: h[k] always pairs with the sample k steps older than the newest.
  logic [AW-1:0]             rd_idx;
  logic signed [2*WIDTH-1:0] product;
  logic signed [ACCW-1:0]    product_ext;
  logic signed [ACCW-1:0]    acc_biased;
  logic signed [ACCW-1:0]    acc_round;
  logic [WIDTH-1:0]          y_sat;

  assign rd_idx      = wr_ptr_reg - k_reg;
  assign product     = coef_reg[k_reg] * delay_reg[rd_idx];
  assign product_ext = {{(ACCW-2*WIDTH){product[2*WIDTH-1]}}, product};
  assign acc_biased  = acc_reg + HALF_LSB;
  assign acc_round   = acc_biased >>> (WIDTH-1);

  always_comb begin
    if (acc_round > SAT_MAX) begin
      y_sat = SAT_MAX[WIDTH-1:0];
    end else if (acc_round < SAT_MIN) begin
      y_sat = SAT_MIN[WIDTH-1:0];
    end else begin
      y_sat = acc_round[WIDTH-1:0];
    end
  end

  // x_ready drops combinationally with RST so nothing is accepted during reset.
  assign x_ready = (state_reg == IDLE) && !RST;
  assign busy    = (state_reg != IDLE);
  assign y       = y_reg;
  assign y_valid = y_valid_reg;

  always_comb begin
    state_next   = state_reg;
    wr_ptr_next  = wr_ptr_reg;
    k_next       = k_reg;
    acc_next     = acc_reg;
    y_next       = y_reg;
    y_valid_next = 1'b0;
    accept       = 1'b0;
    coef_wr_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (x_valid && x_ready) begin
          accept      = 1'b1;
          wr_ptr_next = wr_ptr_reg + AW'(1);
          acc_next    = '0;
          k_next      = '0;
          state_next  = MAC;
        end else if (coef_we) begin
          // Coefficients only change when no sequence is starting.
          coef_wr_en = 1'b1;
        end
      end
      MAC: begin
        acc_next = acc_reg + product_ext;
        k_next   = k_reg + AW'(1);
        if (k_reg == AW'(NTAPS-1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        y_next       = y_sat;
        y_valid_next = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      k_reg       <= '0;
      acc_reg     <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_ptr_reg  <= wr_ptr_next;
      k_reg       <= k_next;
      acc_reg     <= acc_next;
      y_reg       <= y_next;
      y_valid_reg <= y_valid_next;
    end
  end

  // Coefficient and delay-line storage are cleared on reset so an aborted
  // sequence leaves no stale samples behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_reg[i]  <= '0;
        delay_reg[i] <= '0;
      end
    end else begin
      if (coef_wr_en) begin
        coef_reg[coef_addr] <= coef_data;
      end
      if (accept) begin
        // The newest sample lands at the advanced pointer, overwriting the oldest.
        delay_reg[wr_ptr_next] <= x;
      end
    end
  end

endmodule
